branch_sequencer: RTL and testbench

//   Control-step sequencer for conditional branches (br family) in the single-bus CPU.

---
 rtl/branch_sequencer_if.sv | 42 ++++
 rtl/branch_sequencer.sv | 98 +++++++++
 tb/tb_branch_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// rtl/branch_sequencer_if.sv - control-unit <-> branch sequencer handshake and strobe bundle
//
// Purpose: carries the hand-off request (start/ir/con) from the control unit and the
// control strobes and status returned by the branch sequencer.
// Ports (signals):
//   start, ir[31:0], con                      control unit -> sequencer
//   gra, r_out, con_in, pc_out, y_in, c_out,
//   alu_add, z_in, zlow_out, pc_in            sequencer -> datapath strobes
//   busy, done, taken, illegal                sequencer -> control unit status
// Modports: master = control unit side, slave = sequencer side.

interface branch_sequencer_if;
    logic        start;
    logic [31:0] ir;
    logic        con;
    logic        gra;
    logic        r_out;
    logic        con_in;
    logic        pc_out;
    logic        y_in;
    logic        c_out;
    logic        alu_add;
    logic        z_in;
    logic        zlow_out;
    logic        pc_in;
    logic        busy;
    logic        done;
    logic        taken;
    logic        illegal;

    modport master (
        output start, ir, con,
        input  gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in,
        input  busy, done, taken, illegal
    );

    modport slave (
        input  start, ir, con,
        output gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in,
        output busy, done, taken, illegal
    );
endinterface

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - conditional-branch control-step sequencer for the single-bus CPU
//
// Purpose: on a start carrying a br-family instruction, steps through
// EVAL -> PCY -> ADD -> PCLD -> DONE, strobing the datapath so that CON samples the
// branch condition and, when taken, PC <- PC + C. Hands back to the control unit with done.
// Ports:
//   clock   rising-edge clock
//   reset   synchronous, active-high reset
//   bus     branch_sequencer_if.slave (start/ir/con in; datapath strobes and status out)
// Parameters:
//   BR_OPCODE       IR[31:27] value of a conditional branch
//   SKIP_NOT_TAKEN  1: go straight from PCY to DONE when the branch will not be taken

module branch_sequencer #(
    parameter logic [4:0] BR_OPCODE      = 5'b10010,
    parameter bit         SKIP_NOT_TAKEN = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    branch_sequencer_if.slave   bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EVAL = 3'd1;
    localparam logic [2:0] S_PCY  = 3'd2;
    localparam logic [2:0] S_ADD  = 3'd3;
    localparam logic [2:0] S_PCLD = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0] state;
    logic [2:0] state_nxt;
    // Only the C2 condition field of the accepted instruction is needed later on.
    logic [3:0] cond_q;
    logic       con_q;
    logic       taken_q;
    logic       illegal_q;

    logic       br_hit;
    logic       accept;
    logic       cond_ok;
    logic       take_now;

    assign br_hit   = (bus.ir[31:27] == BR_OPCODE);
    assign accept   = (state == S_IDLE) && bus.start && br_hit;
    // brzr/brnz/brpl/brmi are codes 0..3; every other code is a never-taken branch.
    assign cond_ok  = (cond_q <= 4'd3);
    assign take_now = con_q & cond_ok;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_EVAL;
            S_EVAL: state_nxt = S_PCY;
            // CON has settled after EVAL, so the live value already decides the skip.
            S_PCY:  state_nxt = (SKIP_NOT_TAKEN && !(bus.con && cond_ok)) ? S_DONE : S_ADD;
            S_ADD:  state_nxt = S_PCLD;
            S_PCLD: state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cond_q    <= 4'd0;
            con_q     <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            illegal_q <= (state == S_IDLE) && bus.start && !br_hit;
            if (accept) begin
                cond_q  <= bus.ir[22:19];
                taken_q <= 1'b0;
            end
            if (state == S_PCY) con_q <= bus.con;
            // Decision is registered as PCLD ends so it is already valid while done pulses.
            if (state == S_PCLD) taken_q <= take_now;
        end
    end

    assign bus.gra      = (state == S_EVAL);
    assign bus.r_out    = (state == S_EVAL);
    assign bus.con_in   = (state == S_EVAL);
    assign bus.pc_out   = (state == S_PCY);
    assign bus.y_in     = (state == S_PCY);
    assign bus.c_out    = (state == S_ADD);
    assign bus.alu_add  = (state == S_ADD);
    assign bus.z_in     = (state == S_ADD);
    assign bus.zlow_out = (state == S_PCLD);
    assign bus.pc_in    = (state == S_PCLD) && take_now;
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
    assign bus.taken    = taken_q;
    assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - self-checking bench for branch_sequencer (fixed and skip variants)

module tb_branch_sequencer;

    localparam logic [4:0] BR_OP = 5'b10010;

    // Bit positions of the packed strobe/status vector.
    localparam int B_GRA = 12, B_ROUT = 11, B_CONIN = 10, B_PCOUT = 9, B_YIN = 8;
    localparam int B_COUT = 7, B_ADD = 6, B_ZIN = 5, B_ZLOW = 4, B_PCIN = 3;
    localparam int B_BUSY = 2, B_DONE = 1, B_ILL = 0;

    logic clock = 1'b0;
    logic reset = 1'b1;

    branch_sequencer_if ifa ();
    branch_sequencer_if ifb ();

    branch_sequencer #(.BR_OPCODE(BR_OP), .SKIP_NOT_TAKEN(1'b0)) dut_a (
        .clock(clock), .reset(reset), .bus(ifa.slave));
    branch_sequencer #(.BR_OPCODE(BR_OP), .SKIP_NOT_TAKEN(1'b1)) dut_b (
        .clock(clock), .reset(reset), .bus(ifb.slave));

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit model_taken = 1'b0;

    logic [12:0] obs_a [12];
    logic [12:0] obs_b [12];
    logic        tk_a  [12];
    logic        tk_b  [12];

    // ---------------- reference model ----------------
    function automatic logic [12:0] bits(input int p0, input int p1, input int p2, input int p3);
        logic [12:0] v;
        v = '0;
        if (p0 >= 0) v[p0] = 1'b1;
        if (p1 >= 0) v[p1] = 1'b1;
        if (p2 >= 0) v[p2] = 1'b1;
        if (p3 >= 0) v[p3] = 1'b1;
        return v;
    endfunction

    function automatic bit will_take(input logic [31:0] ir_val, input bit con_val);
        return con_val && (ir_val[22:19] < 4);
    endfunction

    // Expected vector k cycles after the start edge: a list of control steps.
    function automatic logic [12:0] expect_vec(input bit skip, input logic [31:0] ir_val,
                                               input bit con_val, input int k);
        logic [12:0] steps[$];
        bit take;
        if (ir_val[31:27] != BR_OP) return (k == 0) ? bits(B_ILL, -1, -1, -1) : 13'd0;
        take = will_take(ir_val, con_val);
        steps.push_back(bits(B_GRA, B_ROUT, B_CONIN, B_BUSY));
        steps.push_back(bits(B_PCOUT, B_YIN, B_BUSY, -1));
        if (!(skip && !take)) begin
            steps.push_back(bits(B_COUT, B_ADD, B_ZIN, B_BUSY));
            steps.push_back(bits(B_ZLOW, B_BUSY, take ? B_PCIN : -1, -1));
        end
        steps.push_back(bits(B_DONE, B_BUSY, -1, -1));
        return (k < steps.size()) ? steps[k] : 13'd0;
    endfunction

    function automatic int seq_len(input bit skip, input logic [31:0] ir_val, input bit con_val);
        if (ir_val[31:27] != BR_OP) return 0;
        return (skip && !will_take(ir_val, con_val)) ? 3 : 5;
    endfunction

    function automatic logic [31:0] make_ir(input logic [4:0] op, input logic [3:0] c2);
        return {op, 4'($urandom), c2, 19'($urandom)};
    endfunction

    // ---------------- stimulus / observation ----------------
    function automatic logic [12:0] pack_a();
        return {ifa.gra, ifa.r_out, ifa.con_in, ifa.pc_out, ifa.y_in, ifa.c_out, ifa.alu_add,
                ifa.z_in, ifa.zlow_out, ifa.pc_in, ifa.busy, ifa.done, ifa.illegal};
    endfunction

    function automatic logic [12:0] pack_b();
        return {ifb.gra, ifb.r_out, ifb.con_in, ifb.pc_out, ifb.y_in, ifb.c_out, ifb.alu_add,
                ifb.z_in, ifb.zlow_out, ifb.pc_in, ifb.busy, ifb.done, ifb.illegal};
    endfunction

    task automatic drive(input logic s, input logic [31:0] i, input logic c);
        ifa.start = s; ifa.ir = i; ifa.con = c;
        ifb.start = s; ifb.ir = i; ifb.con = c;
    endtask

    task automatic sample(input int k);
        obs_a[k] = pack_a(); obs_b[k] = pack_b();
        tk_a[k]  = ifa.taken; tk_b[k] = ifb.taken;
    endtask

    // One start pulse, then 7 observed cycles; ir and con are scrambled where they must be ignored.
    task automatic run_seq(input logic [31:0] ir_val, input bit con_val);
        @(negedge clock);
        drive(1'b1, ir_val, con_val);
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            sample(k);
            drive(1'b0, $urandom, (k <= 1) ? con_val : 1'($urandom));
        end
        if (ir_val[31:27] == BR_OP) model_taken = will_take(ir_val, con_val);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_taken = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        sample(0);
        checks++;
        if (obs_a[0] !== 13'd0 || tk_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: got vec=%b taken=%b, want all zero", obs_a[0], tk_a[0]);
        end
        checks++;
        if (obs_b[0] !== 13'd0 || tk_b[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: got vec=%b taken=%b, want all zero", obs_b[0], tk_b[0]);
        end
    endtask

    task automatic test_directed(input string name, input logic [31:0] ir_val, input bit con_val);
        bit prev_taken;
        prev_taken = model_taken;
        run_seq(ir_val, con_val);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (obs_a[k] !== expect_vec(1'b0, ir_val, con_val, k)) begin
                errors++;
                $display("FAIL %s_fixed cycle %0d: got %b want %b", name, k, obs_a[k],
                         expect_vec(1'b0, ir_val, con_val, k));
            end
            checks++;
            if (obs_b[k] !== expect_vec(1'b1, ir_val, con_val, k)) begin
                errors++;
                $display("FAIL %s_skip cycle %0d: got %b want %b", name, k, obs_b[k],
                         expect_vec(1'b1, ir_val, con_val, k));
            end
        end
        checks++;
        if (tk_a[0] !== ((ir_val[31:27] == BR_OP) ? 1'b0 : prev_taken) || tk_b[0] !== tk_a[0]) begin
            errors++;
            $display("FAIL %s_taken_at_start: got a=%b b=%b", name, tk_a[0], tk_b[0]);
        end
        checks++;
        if (tk_a[6] !== model_taken || tk_b[6] !== model_taken) begin
            errors++;
            $display("FAIL %s_taken_final: got a=%b b=%b want %b", name, tk_a[6], tk_b[6], model_taken);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ir_val;
        ir_val = make_ir(BR_OP, 4'd0);
        @(negedge clock);
        drive(1'b1, ir_val, 1'b1);
        @(negedge clock);          // EVAL
        drive(1'b0, ir_val, 1'b1);
        @(negedge clock);          // PCY
        @(negedge clock);          // ADD
        sample(0);
        reset = 1'b1;
        @(negedge clock);
        sample(1);
        reset = 1'b0;
        model_taken = 1'b0;
        checks++;
        if (obs_a[0] !== expect_vec(1'b0, ir_val, 1'b1, 2)) begin
            errors++;
            $display("FAIL reset_mid_in_add: got %b want %b", obs_a[0], expect_vec(1'b0, ir_val, 1'b1, 2));
        end
        checks++;
        if (obs_a[1] !== 13'd0 || obs_b[1] !== 13'd0 || tk_a[1] !== 1'b0 || tk_b[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: got a=%b b=%b, want zero", obs_a[1], obs_b[1]);
        end
        test_directed("after_reset", make_ir(BR_OP, 4'd2), 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [4:0]  op;
            logic [31:0] ir_val;
            bit          con_val;
            bit          prev_taken;
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : BR_OP;
            ir_val = make_ir(op, 4'($urandom));
            con_val = 1'($urandom);
            prev_taken = model_taken;
            run_seq(ir_val, con_val);
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (obs_a[k] !== expect_vec(1'b0, ir_val, con_val, k) ||
                    obs_b[k] !== expect_vec(1'b1, ir_val, con_val, k)) begin
                    errors++;
                    $display("FAIL random%0d cycle %0d ir=%h con=%b: got a=%b b=%b want a=%b b=%b",
                             n, k, ir_val, con_val, obs_a[k], obs_b[k],
                             expect_vec(1'b0, ir_val, con_val, k), expect_vec(1'b1, ir_val, con_val, k));
                end
                checks++;
                if ($countones({obs_a[k][B_ROUT], obs_a[k][B_PCOUT], obs_a[k][B_COUT], obs_a[k][B_ZLOW]}) > 1 ||
                    $countones({obs_b[k][B_ROUT], obs_b[k][B_PCOUT], obs_b[k][B_COUT], obs_b[k][B_ZLOW]}) > 1) begin
                    errors++;
                    $display("FAIL random%0d bus_drivers cycle %0d: got a=%b b=%b, want at most one",
                             n, k, obs_a[k], obs_b[k]);
                end
            end
            checks++;
            if (tk_a[6] !== model_taken || tk_b[6] !== model_taken) begin
                errors++;
                $display("FAIL random%0d taken: got a=%b b=%b want %b (prev %b)",
                         n, tk_a[6], tk_b[6], model_taken, prev_taken);
            end
        end
    endtask

    // start held high throughout: starts during a sequence are ignored, the first IDLE cycle accepts.
    task automatic test_back_to_back();
        logic [31:0] ir_val;
        int len_a, len_b;
        ir_val = make_ir(BR_OP, 4'd1);
        len_a = seq_len(1'b0, ir_val, 1'b0) + 1;
        len_b = seq_len(1'b1, ir_val, 1'b0) + 1;
        @(negedge clock);
        drive(1'b1, ir_val, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            sample(k);
        end
        drive(1'b0, '0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (obs_a[k] !== expect_vec(1'b0, ir_val, 1'b0, k % len_a)) begin
                errors++;
                $display("FAIL back_to_back_fixed cycle %0d: got %b want %b", k, obs_a[k],
                         expect_vec(1'b0, ir_val, 1'b0, k % len_a));
            end
            checks++;
            if (obs_b[k] !== expect_vec(1'b1, ir_val, 1'b0, k % len_b)) begin
                errors++;
                $display("FAIL back_to_back_skip cycle %0d: got %b want %b", k, obs_b[k],
                         expect_vec(1'b1, ir_val, 1'b0, k % len_b));
            end
        end
        repeat (8) @(negedge clock);
        do_reset();
    endtask

    initial begin
        drive(1'b0, '0, 1'b0);
        test_reset();
        test_directed("brzr_taken", make_ir(BR_OP, 4'd0), 1'b1);
        test_directed("brnz_not_taken", make_ir(BR_OP, 4'd1), 1'b0);
        test_directed("code7_con1", make_ir(BR_OP, 4'd7), 1'b1);
        test_directed("brmi_taken", make_ir(BR_OP, 4'd3), 1'b1);
        test_directed("code4_con1", make_ir(BR_OP, 4'd4), 1'b1);
        test_directed("illegal_op", make_ir(5'b00011, 4'd0), 1'b1);
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
